// File: rtl/sdram_if_pkg.sv
// Command codes, responder state encoding and bus width defaults shared by the
// SDRAM responder and the DMA top.
package sdram_if_pkg;

    localparam int SDRAM_DATA_W = 64;
    localparam int SDRAM_ADDR_W = 8;

    localparam logic [1:0] SDRAM_CMD_IDLE    = 2'b00;
    localparam logic [1:0] SDRAM_CMD_READ    = 2'b01;
    localparam logic [1:0] SDRAM_CMD_WRITE   = 2'b10;
    localparam logic [1:0] SDRAM_CMD_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        READ_WAIT  = 2'b01,
        WR_RECOVER = 2'b10,
        REFRESH    = 2'b11
    } sdram_state_e;

endpackage

// File: rtl/sdram_slave_ctrl_if.sv
// DMA <-> SDRAM responder port: command/address/data from the DMA, read data and
// status back, plus the boot-time preload strobe.
interface sdram_slave_ctrl_if import sdram_if_pkg::*; #(
    parameter int DATA_W = SDRAM_DATA_W,
    parameter int ADDR_W = SDRAM_ADDR_W
) ();

    logic [1:0]        sdram_enable;
    logic [ADDR_W-1:0] sdram_addr_out;
    logic [DATA_W-1:0] data_sdram_out;
    logic [DATA_W-1:0] sdram_data_in;
    logic              sdram_ready;
    logic              rd_valid;
    logic              err_flag;
    logic              init_we;
    logic [ADDR_W-1:0] init_addr;
    logic [DATA_W-1:0] init_data;

    modport master (
        output sdram_enable, sdram_addr_out, data_sdram_out,
        output init_we, init_addr, init_data,
        input  sdram_data_in, sdram_ready, rd_valid, err_flag
    );

    modport slave (
        input  sdram_enable, sdram_addr_out, data_sdram_out,
        input  init_we, init_addr, init_data,
        output sdram_data_in, sdram_ready, rd_valid, err_flag
    );

endinterface

// File: rtl/sdram_refresh_timer.sv
// Free-running refresh interval counter; raises a sticky request on every wrap
// that stays up until the controller reports the refresh finished.
module sdram_refresh_timer #(
    parameter int REFRESH_PERIOD = 64
) (
    input  logic clk_h,
    input  logic rst_n,
    input  logic clear_i,
    output logic wrap_o,
    output logic pending_o
);

    localparam int CNT_W = $clog2(REFRESH_PERIOD);

    logic [CNT_W-1:0] cnt_q;
    logic             pending_q;

    assign wrap_o    = (cnt_q == CNT_W'(REFRESH_PERIOD - 1));
    assign pending_o = pending_q;

    // A new wrap outranks a clear so a late refresh never swallows the next request.
    always_ff @(posedge clk_h or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            pending_q <= 1'b0;
        end else begin
            cnt_q <= wrap_o ? '0 : cnt_q + 1'b1;
            if (wrap_o) begin
                pending_q <= 1'b1;
            end else if (clear_i) begin
                pending_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sdram_slave_ctrl.sv
// SDRAM-side responder for the DMA port: fixed-latency reads, one-cycle write
// recovery and periodic refresh stalls over an inferred register-file array.
module sdram_slave_ctrl import sdram_if_pkg::*; #(
    parameter int DATA_W         = SDRAM_DATA_W,
    parameter int ADDR_W         = SDRAM_ADDR_W,
    parameter int DEPTH          = 256,
    parameter int RD_LAT         = 2,
    parameter int REFRESH_PERIOD = 64,
    parameter int REFRESH_CYCLES = 4
) (
    input  logic              clk_h,
    input  logic              rst_n,
    sdram_slave_ctrl_if.slave bus
);

    localparam int IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WAIT_MAX = (RD_LAT > REFRESH_CYCLES) ? RD_LAT : REFRESH_CYCLES;
    localparam int WAIT_W   = $clog2(WAIT_MAX + 1);

    sdram_state_e      state_q, state_d;
    logic [WAIT_W-1:0] waitCnt_q, waitCnt_d;
    logic [DATA_W-1:0] dataOut_q;
    logic [IDX_W-1:0]  rdIdx_q;
    logic              rdInRange_q, rdValid_q, err_q;

    logic              ready, acceptRd, acceptWr, illegalCmd, readDone, refreshDone;
    logic              refreshWrap, refreshPending;
    logic              cmdInRange, initInRange;
    logic [IDX_W-1:0]  cmdIdx, initIdx, wrIdx;
    logic [DATA_W-1:0] wrData;
    logic              wrEn;

    logic [DATA_W-1:0] mem [DEPTH];

    assign cmdInRange  = ({1'b0, bus.sdram_addr_out} < (ADDR_W + 1)'(DEPTH));
    assign initInRange = ({1'b0, bus.init_addr} < (ADDR_W + 1)'(DEPTH));
    assign cmdIdx      = bus.sdram_addr_out[IDX_W-1:0];
    assign initIdx     = bus.init_addr[IDX_W-1:0];

    sdram_refresh_timer #(
        .REFRESH_PERIOD(REFRESH_PERIOD)
    ) u_refresh (
        .clk_h    (clk_h),
        .rst_n    (rst_n),
        .clear_i  (refreshDone),
        .wrap_o   (refreshWrap),
        .pending_o(refreshPending)
    );

    always_ff @(posedge clk_h or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            waitCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            waitCnt_q <= waitCnt_d;
        end
    end

    // A command accepted on the wrapping edge wins; the refresh is taken on the next return to IDLE.
    always_comb begin
        state_d   = state_q;
        waitCnt_d = waitCnt_q;
        case (state_q)
            IDLE: begin
                if (acceptRd) begin
                    state_d   = READ_WAIT;
                    waitCnt_d = WAIT_W'(RD_LAT - 1);
                end else if (acceptWr) begin
                    state_d = WR_RECOVER;
                end else if (refreshPending || refreshWrap) begin
                    state_d   = REFRESH;
                    waitCnt_d = WAIT_W'(REFRESH_CYCLES - 1);
                end
            end
            READ_WAIT, REFRESH: begin
                if (waitCnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    waitCnt_d = waitCnt_q - 1'b1;
                end
            end
            WR_RECOVER: state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        ready       = (state_q == IDLE) && !refreshPending && !bus.init_we;
        acceptRd    = 1'b0;
        acceptWr    = 1'b0;
        illegalCmd  = 1'b0;
        readDone    = (state_q == READ_WAIT) && (waitCnt_q == '0);
        refreshDone = (state_q == REFRESH) && (waitCnt_q == '0);
        if (ready) begin
            case (bus.sdram_enable)
                SDRAM_CMD_IDLE:    ;
                SDRAM_CMD_READ:    acceptRd   = 1'b1;
                SDRAM_CMD_WRITE:   acceptWr   = 1'b1;
                SDRAM_CMD_ILLEGAL: illegalCmd = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk_h or negedge rst_n) begin
        if (!rst_n) begin
            dataOut_q   <= '0;
            rdValid_q   <= 1'b0;
            err_q       <= 1'b0;
            rdIdx_q     <= '0;
            rdInRange_q <= 1'b0;
        end else begin
            rdValid_q <= readDone;
            if (readDone) begin
                dataOut_q <= rdInRange_q ? mem[rdIdx_q] : '0;
            end
            if (acceptRd) begin
                rdIdx_q     <= cmdIdx;
                rdInRange_q <= cmdInRange;
            end
            if (illegalCmd || ((acceptRd || acceptWr) && !cmdInRange)) begin
                err_q <= 1'b1;
            end
        end
    end

    // Single write port: preload and DMA writes are mutually exclusive because init_we drops ready.
    always_comb begin
        wrEn   = 1'b0;
        wrIdx  = cmdIdx;
        wrData = bus.data_sdram_out;
        if (bus.init_we) begin
            wrEn   = initInRange;
            wrIdx  = initIdx;
            wrData = bus.init_data;
        end else if (acceptWr) begin
            wrEn = cmdInRange;
        end
    end

    always_ff @(posedge clk_h) begin
        if (wrEn) begin
            mem[wrIdx] <= wrData;
        end
    end

    assign bus.sdram_data_in = dataOut_q;
    assign bus.sdram_ready   = ready;
    assign bus.rd_valid      = rdValid_q;
    assign bus.err_flag      = err_q;

endmodule

// File: tb/tb_sdram_slave_ctrl.sv
// Directed bench for sdram_slave_ctrl: a full-size instance plus a 32-word one
// for out-of-range behaviour, with hand-computed expectations.
module tb_sdram_slave_ctrl;
    import sdram_if_pkg::*;

    logic clk_h = 1'b0;
    logic rst_n = 1'b0;
    int   checkCount = 0;
    int   passCount  = 0;
    int   cycleCnt   = 0;

    always #5 clk_h = ~clk_h;
    always @(posedge clk_h) cycleCnt <= cycleCnt + 1;

    sdram_slave_ctrl_if #(.DATA_W(64), .ADDR_W(8)) bus ();
    sdram_slave_ctrl_if #(.DATA_W(64), .ADDR_W(8)) bus32 ();

    sdram_slave_ctrl #(
        .DATA_W(64), .ADDR_W(8), .DEPTH(256), .RD_LAT(2),
        .REFRESH_PERIOD(64), .REFRESH_CYCLES(4)
    ) dut (
        .clk_h(clk_h),
        .rst_n(rst_n),
        .bus  (bus)
    );

    sdram_slave_ctrl #(
        .DATA_W(64), .ADDR_W(8), .DEPTH(32), .RD_LAT(2),
        .REFRESH_PERIOD(64), .REFRESH_CYCLES(4)
    ) dut32 (
        .clk_h(clk_h),
        .rst_n(rst_n),
        .bus  (bus32)
    );

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Waits (bounded) for ready, presents the command for exactly one accepting edge.
    task automatic applyStimulus(input logic [1:0] cmd, input logic [7:0] addr, input logic [63:0] data);
        int n = 0;
        @(negedge clk_h);
        while (!bus.sdram_ready && n < 200) begin
            @(negedge clk_h);
            n++;
        end
        checkOutput("cmd_ready", 64'(bus.sdram_ready), 64'd1);
        bus.sdram_enable   = cmd;
        bus.sdram_addr_out = addr;
        bus.data_sdram_out = data;
        @(posedge clk_h);
        #1;
        bus.sdram_enable = SDRAM_CMD_IDLE;
    endtask

    task automatic readWord(input logic [7:0] addr, output logic [63:0] data);
        int n = 0;
        applyStimulus(SDRAM_CMD_READ, addr, 64'd0);
        @(negedge clk_h);
        while (!bus.rd_valid && n < 20) begin
            @(negedge clk_h);
            n++;
        end
        checkOutput("rd_valid_seen", 64'(bus.rd_valid), 64'd1);
        data = bus.sdram_data_in;
    endtask

    task automatic preload(input logic [7:0] addr, input logic [63:0] data);
        @(negedge clk_h);
        bus.init_we   = 1'b1;
        bus.init_addr = addr;
        bus.init_data = data;
        @(posedge clk_h);
        #1;
        bus.init_we = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [63:0] rdData;
        int          n;
        int          lowCount;
        int          refreshStart;
        bit          sawValid;

        bus.sdram_enable     = SDRAM_CMD_IDLE;
        bus.sdram_addr_out   = '0;
        bus.data_sdram_out   = '0;
        bus.init_we          = 1'b0;
        bus.init_addr        = '0;
        bus.init_data        = '0;
        bus32.sdram_enable   = SDRAM_CMD_IDLE;
        bus32.sdram_addr_out = '0;
        bus32.data_sdram_out = '0;
        bus32.init_we        = 1'b0;
        bus32.init_addr      = '0;
        bus32.init_data      = '0;

        repeat (2) @(negedge clk_h);
        checkOutput("reset_data", bus.sdram_data_in, 64'd0);
        checkOutput("reset_rd_valid", 64'(bus.rd_valid), 64'd0);
        checkOutput("reset_err", 64'(bus.err_flag), 64'd0);
        checkOutput("reset_ready", 64'(bus.sdram_ready), 64'd1);
        rst_n = 1'b1;

        $display("[TB] test 1: preload + fixed-latency read");
        preload(8'd5, 64'hA5A5_0000_0000_0005);
        applyStimulus(SDRAM_CMD_READ, 8'd5, 64'd0);
        @(negedge clk_h);
        checkOutput("t1_ready_T", 64'(bus.sdram_ready), 64'd0);
        checkOutput("t1_valid_T", 64'(bus.rd_valid), 64'd0);
        @(negedge clk_h);
        checkOutput("t1_ready_T1", 64'(bus.sdram_ready), 64'd0);
        checkOutput("t1_valid_T1", 64'(bus.rd_valid), 64'd0);
        @(negedge clk_h);
        checkOutput("t1_valid_T2", 64'(bus.rd_valid), 64'd1);
        checkOutput("t1_data_T2", bus.sdram_data_in, 64'hA5A5_0000_0000_0005);
        checkOutput("t1_ready_T2", 64'(bus.sdram_ready), 64'd1);
        @(negedge clk_h);
        checkOutput("t1_valid_pulse", 64'(bus.rd_valid), 64'd0);
        checkOutput("t1_data_hold", bus.sdram_data_in, 64'hA5A5_0000_0000_0005);

        $display("[TB] test 2: write then read back");
        applyStimulus(SDRAM_CMD_WRITE, 8'h40, 64'hDEAD_BEEF_0123_4567);
        @(negedge clk_h);
        checkOutput("t2_wr_recover", 64'(bus.sdram_ready), 64'd0);
        @(negedge clk_h);
        checkOutput("t2_wr_ready", 64'(bus.sdram_ready), 64'd1);
        readWord(8'h40, rdData);
        checkOutput("t2_readback", rdData, 64'hDEAD_BEEF_0123_4567);

        $display("[TB] test 4b: out-of-range on the 32-word instance");
        @(negedge clk_h);
        bus32.init_we   = 1'b1;
        bus32.init_addr = 8'd3;
        bus32.init_data = 64'h0000_1111_2222_3333;
        @(posedge clk_h);
        #1;
        bus32.init_we = 1'b0;
        @(negedge clk_h);
        checkOutput("t4_small_ready", 64'(bus32.sdram_ready), 64'd1);
        bus32.sdram_enable   = SDRAM_CMD_READ;
        bus32.sdram_addr_out = 8'd3;
        @(posedge clk_h);
        #1;
        bus32.sdram_enable = SDRAM_CMD_IDLE;
        repeat (3) @(negedge clk_h);
        checkOutput("t4_small_inrange", bus32.sdram_data_in, 64'h0000_1111_2222_3333);
        checkOutput("t4_small_err_clear", 64'(bus32.err_flag), 64'd0);
        checkOutput("t4_small_ready2", 64'(bus32.sdram_ready), 64'd1);
        bus32.sdram_enable   = SDRAM_CMD_READ;
        bus32.sdram_addr_out = 8'd40;
        @(posedge clk_h);
        #1;
        bus32.sdram_enable = SDRAM_CMD_IDLE;
        @(negedge clk_h);
        checkOutput("t4_oor_valid_T", 64'(bus32.rd_valid), 64'd0);
        @(negedge clk_h);
        checkOutput("t4_oor_valid_T1", 64'(bus32.rd_valid), 64'd0);
        @(negedge clk_h);
        checkOutput("t4_oor_valid_T2", 64'(bus32.rd_valid), 64'd1);
        checkOutput("t4_oor_data", bus32.sdram_data_in, 64'd0);
        checkOutput("t4_oor_err", 64'(bus32.err_flag), 64'd1);
        bus32.sdram_enable   = SDRAM_CMD_WRITE;
        bus32.sdram_addr_out = 8'd40;
        bus32.data_sdram_out = 64'hFFFF_FFFF_FFFF_FFFF;
        @(posedge clk_h);
        #1;
        bus32.sdram_enable = SDRAM_CMD_IDLE;
        @(negedge clk_h);
        checkOutput("t4_oor_err_sticky", 64'(bus32.err_flag), 64'd1);

        $display("[TB] test 6: preload collides with DMA write");
        @(negedge clk_h);
        bus.init_we        = 1'b1;
        bus.init_addr      = 8'h10;
        bus.init_data      = 64'h1111_2222_3333_4444;
        bus.sdram_enable   = SDRAM_CMD_WRITE;
        bus.sdram_addr_out = 8'h11;
        bus.data_sdram_out = 64'h5555_6666_7777_8888;
        #1;
        checkOutput("t6_ready_init", 64'(bus.sdram_ready), 64'd0);
        @(posedge clk_h);
        #1;
        bus.init_we = 1'b0;
        @(negedge clk_h);
        checkOutput("t6_not_accepted", 64'(bus.sdram_ready), 64'd1);
        @(posedge clk_h);
        #1;
        bus.sdram_enable = SDRAM_CMD_IDLE;
        @(negedge clk_h);
        checkOutput("t6_accepted", 64'(bus.sdram_ready), 64'd0);
        readWord(8'h10, rdData);
        checkOutput("t6_preload_word", rdData, 64'h1111_2222_3333_4444);
        readWord(8'h11, rdData);
        checkOutput("t6_dma_word", rdData, 64'h5555_6666_7777_8888);

        $display("[TB] test 3: read held across refresh");
        n = 0;
        @(negedge clk_h);
        while (bus.sdram_ready && n < 200) begin
            @(negedge clk_h);
            n++;
        end
        refreshStart       = cycleCnt;
        bus.sdram_enable   = SDRAM_CMD_READ;
        bus.sdram_addr_out = 8'd5;
        lowCount           = 0;
        sawValid           = 1'b0;
        n                  = 0;
        while (!bus.sdram_ready && n < 20) begin
            lowCount++;
            if (bus.rd_valid) sawValid = 1'b1;
            @(negedge clk_h);
            n++;
        end
        checkOutput("t3_refresh_low", 64'(lowCount), 64'd4);
        checkOutput("t3_no_valid", 64'(sawValid), 64'd0);
        @(posedge clk_h);
        #1;
        bus.sdram_enable = SDRAM_CMD_IDLE;
        @(negedge clk_h);
        checkOutput("t3_valid_T", 64'(bus.rd_valid), 64'd0);
        @(negedge clk_h);
        checkOutput("t3_valid_T1", 64'(bus.rd_valid), 64'd0);
        @(negedge clk_h);
        checkOutput("t3_valid_T2", 64'(bus.rd_valid), 64'd1);
        checkOutput("t3_data", bus.sdram_data_in, 64'hA5A5_0000_0000_0005);
        n = 0;
        @(negedge clk_h);
        while (bus.sdram_ready && n < 200) begin
            @(negedge clk_h);
            n++;
        end
        checkOutput("t3_spacing", 64'(cycleCnt - refreshStart), 64'd64);

        $display("[TB] test 4: illegal command");
        checkOutput("t4_err_before", 64'(bus.err_flag), 64'd0);
        applyStimulus(SDRAM_CMD_ILLEGAL, 8'd0, 64'd0);
        @(negedge clk_h);
        checkOutput("t4_err_set", 64'(bus.err_flag), 64'd1);
        checkOutput("t4_stays_idle", 64'(bus.sdram_ready), 64'd1);
        readWord(8'd5, rdData);
        checkOutput("t4_read_after_err", rdData, 64'hA5A5_0000_0000_0005);
        checkOutput("t4_err_sticky", 64'(bus.err_flag), 64'd1);

        $display("[TB] test 5: reset during READ_WAIT");
        applyStimulus(SDRAM_CMD_READ, 8'h40, 64'd0);
        rst_n = 1'b0;
        #1;
        checkOutput("t5_data_cleared", bus.sdram_data_in, 64'd0);
        checkOutput("t5_valid_cleared", 64'(bus.rd_valid), 64'd0);
        checkOutput("t5_err_cleared", 64'(bus.err_flag), 64'd0);
        checkOutput("t5_idle", 64'(bus.sdram_ready), 64'd1);
        sawValid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_h);
            if (bus.rd_valid) sawValid = 1'b1;
        end
        checkOutput("t5_no_valid", 64'(sawValid), 64'd0);
        rst_n = 1'b1;
        @(negedge clk_h);
        checkOutput("t5_ready_after", 64'(bus.sdram_ready), 64'd1);
        readWord(8'h40, rdData);
        checkOutput("t5_read_after", rdData, 64'hDEAD_BEEF_0123_4567);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
